// File: rtl/ir_pkg.sv
// Shared encodings for the instruction-register pipeline controller.
// Opcodes live in instr[3:0]; shift and ori are matched on instr[2:0] only.
package ir_pkg;

  localparam logic [7:0] NOP_INSTR = 8'h0A;
  localparam logic [3:0] STOP_OP   = 4'b0001;
  localparam int         CNT_W     = 8;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_STOP  = 4'b0001;

  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_ORI   = 3'b111;

  // ori always reads and writes this register implicitly
  localparam logic [1:0] ORI_REG = 2'd1;

endpackage

// File: rtl/ir_regdecode.sv
// Register-usage decode of one instruction: which register it writes and
// which registers it reads.
module ir_regdecode
  import ir_pkg::*;
(
  input  logic [7:0] instr,
  output logic       dest_valid,
  output logic [1:0] dest,
  output logic       src1_valid,
  output logic [1:0] src1,
  output logic       src2_valid,
  output logic [1:0] src2
);

  logic [3:0] op;
  assign op = instr[3:0];

  always_comb begin
    dest_valid = 1'b0;
    dest       = instr[7:6];
    src1_valid = 1'b0;
    src1       = instr[7:6];
    src2_valid = 1'b0;
    src2       = instr[5:4];
    if (op[2:0] == OP_SHIFT) begin
      dest_valid = 1'b1;
      src1_valid = 1'b1;
    end else if (op[2:0] == OP_ORI) begin
      dest_valid = 1'b1;
      dest       = ORI_REG;
      src1_valid = 1'b1;
      src1       = ORI_REG;
    end else begin
      case (op)
        OP_LOAD: begin
          dest_valid = 1'b1;
          src2_valid = 1'b1;
        end
        OP_ADD, OP_SUB, OP_NAND: begin
          dest_valid = 1'b1;
          src1_valid = 1'b1;
          src2_valid = 1'b1;
        end
        OP_STORE: begin
          src1_valid = 1'b1;
          src2_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ir_pipeline_ctrl.sv
// IR1..IR4 instruction-register chain with read-after-write stall insertion,
// taken-branch flush, stop-driven fetch halt and a saturating stall counter.
module ir_pipeline_ctrl #(
  parameter logic [7:0] NOP_INSTR = ir_pkg::NOP_INSTR,
  parameter logic [3:0] STOP_OP   = ir_pkg::STOP_OP,
  parameter int         CNT_W     = ir_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       IMemOut,
  input  logic             BranchTaken,
  output logic [7:0]       IR1Out,
  output logic [7:0]       IR2Out,
  output logic [7:0]       IR3Out,
  output logic [7:0]       IR4Out,
  output logic             PCWrite,
  output logic             Stall,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  import ir_pkg::*;

  logic       fetch_halt;
  logic       d1_v, s1_v1, s2_v1;
  logic       d2_v, s1_v2, s2_v2;
  logic       d3_v, s1_v3, s2_v3;
  logic [1:0] d1, s1_1, s2_1;
  logic [1:0] d2, s1_2, s2_2;
  logic [1:0] d3, s1_3, s2_3;
  logic       hz_src1, hz_src2, hz;

  ir_regdecode u_dec1 (
    .instr(IR1Out), .dest_valid(d1_v), .dest(d1),
    .src1_valid(s1_v1), .src1(s1_1), .src2_valid(s2_v1), .src2(s2_1)
  );
  ir_regdecode u_dec2 (
    .instr(IR2Out), .dest_valid(d2_v), .dest(d2),
    .src1_valid(s1_v2), .src1(s1_2), .src2_valid(s2_v2), .src2(s2_2)
  );
  ir_regdecode u_dec3 (
    .instr(IR3Out), .dest_valid(d3_v), .dest(d3),
    .src1_valid(s1_v3), .src1(s1_3), .src2_valid(s2_v3), .src2(s2_3)
  );

  // IR4 results are forwarded, so only IR2/IR3 producers can block IR1
  assign hz_src1 = s1_v1 & ((d2_v & (s1_1 == d2)) | (d3_v & (s1_1 == d3)));
  assign hz_src2 = s2_v1 & ((d2_v & (s2_1 == d2)) | (d3_v & (s2_1 == d3)));
  assign hz      = hz_src1 | hz_src2;

  assign Stall   = hz & ~BranchTaken;
  assign PCWrite = BranchTaken | (~Stall & ~fetch_halt & ~Halted);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      IR1Out     <= NOP_INSTR;
      IR2Out     <= NOP_INSTR;
      IR3Out     <= NOP_INSTR;
      IR4Out     <= NOP_INSTR;
      Halted     <= 1'b0;
      fetch_halt <= 1'b0;
      StallCount <= '0;
    end else begin
      IR4Out <= IR3Out;
      if (IR3Out[3:0] == STOP_OP) Halted <= 1'b1;
      if (BranchTaken) begin
        // a stop fetched down the wrong path must not freeze fetch
        IR3Out     <= NOP_INSTR;
        IR2Out     <= NOP_INSTR;
        IR1Out     <= NOP_INSTR;
        fetch_halt <= 1'b0;
      end else if (Stall) begin
        IR3Out <= IR2Out;
        IR2Out <= NOP_INSTR;
        if (StallCount != '1) StallCount <= StallCount + 1'b1;
      end else begin
        IR3Out <= IR2Out;
        IR2Out <= IR1Out;
        if (fetch_halt) begin
          IR1Out <= NOP_INSTR;
        end else begin
          IR1Out <= IMemOut;
          if (IMemOut[3:0] == STOP_OP) fetch_halt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_pipeline_ctrl.sv
// Directed bench for ir_pipeline_ctrl: every retiring instruction is checked
// against a queue of expected (instruction, retire edge) pairs.
module tb_ir_pipeline_ctrl;
  import ir_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IMemOut = 8'h0A;
  logic       BranchTaken = 1'b0;
  logic [7:0] IR1Out, IR2Out, IR3Out, IR4Out;
  logic       PCWrite, Stall, Halted;
  logic [7:0] StallCount;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_instr_q[$];
  int         exp_cyc_q[$];

  ir_pipeline_ctrl dut (
    .clock(clock), .reset(reset), .IMemOut(IMemOut), .BranchTaken(BranchTaken),
    .IR1Out(IR1Out), .IR2Out(IR2Out), .IR3Out(IR3Out), .IR4Out(IR4Out),
    .PCWrite(PCWrite), .Stall(Stall), .Halted(Halted), .StallCount(StallCount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // instr loaded on the next edge retires lat edges from now
  task automatic push(input logic [7:0] instr, input int lat);
    exp_instr_q.push_back(instr);
    exp_cyc_q.push_back(cyc + lat);
  endtask

  always @(negedge clock) begin
    logic [7:0] ei;
    int         ec;
    if (reset && IR4Out !== 8'h0A) begin
      if (exp_instr_q.size() == 0) begin
        chk("retire_unexpected", IR4Out, 8'h0A);
      end else begin
        ei = exp_instr_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("retire_instr", IR4Out, ei);
        chk("retire_cycle", cyc, ec);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_ir1", IR1Out, 8'h0A);
    chk("rst_ir2", IR2Out, 8'h0A);
    chk("rst_ir3", IR3Out, 8'h0A);
    chk("rst_ir4", IR4Out, 8'h0A);
    chk("rst_pcw", PCWrite, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_halt", Halted, 0);
    chk("rst_cnt", StallCount, 0);
    step();

    // load k1 then add using k1: two bubbles
    IMemOut = 8'h40; push(8'h40, 4); step();
    IMemOut = 8'h14; push(8'h14, 6); step();
    IMemOut = 8'h0A;
    chk("lu_stall1", Stall, 1);
    chk("lu_pcw1", PCWrite, 0);
    step();
    chk("lu_stall2", Stall, 1);
    chk("lu_ir2_bubble1", IR2Out, 8'h0A);
    chk("lu_ir1_hold", IR1Out, 8'h14);
    step();
    chk("lu_stall_end", Stall, 0);
    chk("lu_ir4", IR4Out, 8'h40);
    chk("lu_ir2_bubble2", IR2Out, 8'h0A);
    chk("lu_cnt", StallCount, 2);
    step();
    chk("lu_ir2_enter", IR2Out, 8'h14);
    repeat (4) step();

    // independent stream
    IMemOut = 8'hB4; push(8'hB4, 4); step();
    IMemOut = 8'h14; push(8'h14, 4); step();
    IMemOut = 8'h0A;
    chk("ind_stall_a", Stall, 0);
    step();
    chk("ind_stall_b", Stall, 0);
    repeat (4) step();
    chk("ind_cnt", StallCount, 2);

    // one unrelated instruction between producer and consumer: one bubble
    IMemOut = 8'h40; push(8'h40, 4); step();
    IMemOut = 8'hB4; push(8'hB4, 4); step();
    IMemOut = 8'h14; push(8'h14, 5); step();
    IMemOut = 8'h0A;
    chk("gap1_stall", Stall, 1);
    repeat (5) step();
    chk("gap1_cnt", StallCount, 3);

    // two unrelated instructions between: no bubble, IR4 not considered
    IMemOut = 8'h40; push(8'h40, 4); step();
    IMemOut = 8'hB4; push(8'hB4, 4); step();
    IMemOut = 8'hF4; push(8'hF4, 4); step();
    IMemOut = 8'h14; push(8'h14, 4); step();
    IMemOut = 8'h0A;
    chk("gap2_stall", Stall, 0);
    repeat (5) step();
    chk("gap2_cnt", StallCount, 3);

    // taken branch in IR3 while IR1 has a hazard against IR2
    IMemOut = 8'h35; push(8'h35, 4); step();
    IMemOut = 8'h40; step();
    IMemOut = 8'h14; step();
    IMemOut = 8'h0A;
    chk("br_hz", Stall, 1);
    BranchTaken = 1'b1;
    #1;
    chk("br_stall", Stall, 0);
    chk("br_pcw", PCWrite, 1);
    step();
    BranchTaken = 1'b0;
    chk("br_ir4", IR4Out, 8'h35);
    chk("br_ir3", IR3Out, 8'h0A);
    chk("br_ir2", IR2Out, 8'h0A);
    chk("br_ir1", IR1Out, 8'h0A);
    chk("br_cnt", StallCount, 3);
    repeat (3) step();

    // stop fetched on the wrong path of a taken branch
    IMemOut = 8'h35; push(8'h35, 4); step();
    IMemOut = 8'hB4; step();
    IMemOut = 8'h01; step();
    IMemOut = 8'h0A;
    chk("sp_pcw_halted", PCWrite, 0);
    BranchTaken = 1'b1;
    #1;
    chk("sp_pcw_branch", PCWrite, 1);
    step();
    BranchTaken = 1'b0;
    chk("sp_pcw_after", PCWrite, 1);
    chk("sp_ir1", IR1Out, 8'h0A);
    repeat (4) step();
    chk("sp_halt", Halted, 0);
    chk("sp_pcw_late", PCWrite, 1);

    // real stop: fetch freezes, Halted rises when stop reaches IR4
    IMemOut = 8'h01; push(8'h01, 4); step();
    IMemOut = 8'h14;
    chk("st_pcw", PCWrite, 0);
    step();
    chk("st_ir1", IR1Out, 8'h0A);
    chk("st_halt_ir2", Halted, 0);
    IMemOut = 8'h40; step();
    chk("st_halt_ir3", Halted, 0);
    step();
    chk("st_halt_ir4", Halted, 1);
    chk("st_ir4", IR4Out, 8'h01);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("st_halt_hold", Halted, 1);
      chk("st_pcw_hold", PCWrite, 0);
      chk("st_ir1_hold", IR1Out, 8'h0A);
    end

    IMemOut = 8'h0A;
    @(negedge clock);
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rs_halt", Halted, 0);
    chk("rs_pcw", PCWrite, 1);
    step();

    // asynchronous reset in the middle of a stall
    IMemOut = 8'h40; step();
    IMemOut = 8'h14; step();
    IMemOut = 8'h0A; step();
    chk("ar_cnt_pre", StallCount, 1);
    chk("ar_stall_pre", Stall, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_ir1", IR1Out, 8'h0A);
    chk("ar_ir2", IR2Out, 8'h0A);
    chk("ar_ir3", IR3Out, 8'h0A);
    chk("ar_ir4", IR4Out, 8'h0A);
    chk("ar_cnt", StallCount, 0);
    chk("ar_stall", Stall, 0);
    chk("ar_pcw", PCWrite, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    step();

    // 130 load-use pairs = 260 stalls, counter must stick at 255
    for (int k = 0; k < 130; k++) begin
      IMemOut = 8'h40; push(8'h40, 4); step();
      IMemOut = 8'h14; push(8'h14, 6); step();
      IMemOut = 8'h0A;
      repeat (4) step();
    end
    chk("sat_cnt", StallCount, 8'hFF);
    repeat (3) step();
    chk("queue_empty", exp_instr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_pipeline_ctrl.md
Name: ir_pipeline_ctrl

Overview:
- Owns the instruction-register chain IR1→IR2→IR3→IR4 that the register-file and forwarding controller decodes.
- Advances fetched instructions each cycle.
- Detects register-read-after-write hazards that IR4 forwarding cannot cover and inserts bubbles for them.
- Flushes wrong-path instructions on a taken branch and halts fetch on stop.

Parameters:
- NOP_INSTR, 8'h0A, bubble/flush encoding (opcode 1010)
- STOP_OP, 4'b0001, stop opcode in bits [3:0]
- CNT_W, 8, width of stall performance counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IMemOut  in  8  instruction fetched this cycle
- BranchTaken  in  1  branch in IR3 resolved taken this cycle
- IR1Out  out  8  fetch/decode stage instruction
- IR2Out  out  8  register-read stage instruction
- IR3Out  out  8  execute stage instruction
- IR4Out  out  8  writeback stage instruction
- PCWrite  out  1  PC may update this cycle
- Stall  out  1  hazard bubble inserted this cycle
- Halted  out  1  stop has reached IR4 (sticky)
- StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (asynchronous, active-low): IR1..IR4=NOP_INSTR, Halted=0, fetch_halt=0, StallCount=0. Combinational outputs then evaluate to PCWrite=1 and Stall=0.
- Decode of an instruction x. Opcodes are x[3:0]; a shift matches x[2:0]=011 and ori matches x[2:0]=111.
  - dest(x): load(0000), add(0100), sub(0110), nand(1000) and shift write x[7:6]. ori writes register 1. All others write nothing.
  - srcs(IR1): add/sub/nand/store read x[7:6] and x[5:4]. Shift reads x[7:6]. ori reads register 1. load reads x[5:4]. Branches, nop and stop read nothing.
- Hazard: hz = some src of IR1 equals a valid dest(IR2) or a valid dest(IR3). IR4 is forwarded downstream, so it is excluded.
- Stall is combinational: Stall = hz & ~BranchTaken.
- Per rising edge, in priority order:
  1. BranchTaken: IR4<=IR3; IR3, IR2, IR1<=NOP_INSTR; fetch_halt<=0, which cancels a speculative stop.
  2. Stall: IR4<=IR3; IR3<=IR2; IR2<=NOP_INSTR; IR1 holds; StallCount += 1, saturating at all-ones.
  3. Otherwise: IR4<=IR3; IR3<=IR2; IR2<=IR1; IR1<=(fetch_halt ? NOP_INSTR : IMemOut).
- Stop handling:
  - fetch_halt is set on any edge where IMemOut[3:0]==STOP_OP is loaded into IR1.
  - Halted is set on the edge where IR3 holds stop and advances into IR4. It is sticky until reset.
  - Once Halted=1, PCWrite=0 and the chain keeps shifting NOPs.
- PCWrite = BranchTaken | (~Stall & ~fetch_halt & ~Halted).
- Latency: an instruction with no hazard reaches IR4 three edges after entering IR1. Each stall cycle adds one edge.
- A back-to-back producer and consumer costs exactly 2 stall cycles. A gap of one instruction between them costs 1. A gap of two or more costs 0.
- Reset asserted mid-stall or mid-flush overrides everything immediately, because it is asynchronous.

Decomposition:
- Shared package ir_pkg holds:
  - opcode constants (LOAD, STORE, ADD, SUB, NAND, SHIFT, ORI, BZ, BNZ, BPZ, NOP, STOP)
  - NOP_INSTR
  - the ori implicit register index 2'd1
- One sub-module, ir_regdecode, instantiated 3×:
  - inputs: 8-bit instruction
  - outputs: dest_valid, dest[1:0], src1_valid, src1[1:0], src2_valid, src2[1:0]
- Hazard compare, pipeline registers, halt logic and counter are in the top module.

Test Plan:
- Reset check: hold reset=0, then release → IR1..IR4=8'h0A, PCWrite=1, Stall=0, Halted=0, StallCount=0.
- Load-use, back to back: fetch 8'h40 (load k1,(k0)), then 8'h14 (add k0,k1), then NOPs.
  - Stall=1 for exactly 2 cycles, with IR2=8'h0A during each.
  - 8'h14 enters IR2 on the edge where IR4=8'h40.
  - StallCount=2.
- Independent stream: fetch 8'hB4 then 8'h14 → no stall; IR4 shows 8'hB4 then 8'h14 on consecutive cycles.
- Taken branch: IR3=8'h35 (bz), BranchTaken=1, and hz also true in the same cycle.
  - That cycle: Stall=0, PCWrite=1.
  - Next cycle: IR4=8'h35, IR1..IR3=8'h0A.
  - StallCount unchanged.
- Stop: fetch 8'h01 → from the next cycle IR1 receives 8'h0A regardless of IMemOut and PCWrite=0. Halted=1 on the edge where IR4 becomes 8'h01, and stays 1 for 10+ cycles.
- Speculative stop and async reset: fetch 8'h01 while the branch in IR3 is taken → fetch_halt cleared and PCWrite=1. Then assert reset asynchronously mid-stall → all IR=8'h0A and StallCount=0 before the next clock edge.
